// File: rtl/axi_sram_slave.sv
// AXI3 responder in front of a single-port synchronous SRAM.
// Serves one read or write burst at a time. Simultaneous AR/AW requests are arbitrated round-robin.
module axi_sram_slave #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ID_W   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  // read address channel
  input  logic [ID_W-1:0]   arid,
  input  logic [31:0]       araddr,
  input  logic [3:0]        arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  // read data channel
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  // write address channel
  input  logic [ID_W-1:0]   awid,
  input  logic [31:0]       awaddr,
  input  logic [3:0]        awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  // write data channel
  input  logic [ID_W-1:0]   wid,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  // write response channel
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  // SRAM port
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_RESP = 3'd2,
    WR_DATA = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              rd_pri_q, rd_pri_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [31:0]       addr_q, addr_d;
  logic [3:0]        len_q, len_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        burst_q, burst_d;
  logic [3:0]        beat_q, beat_d;
  logic              err_q, err_d;
  logic              last_beat;

  // The write ID is not needed: only one burst is ever outstanding.
  logic unused_wid;
  assign unused_wid = ^wid;

  // Byte address of the next beat; WRAP only for legal wrap lengths, otherwise INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [3:0] len,
                                            input logic [1:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] inc;
    logic [31:0] mask;
    step = 32'(1) << size;
    inc  = a + step;
    mask = ((32'(len) + 32'd1) << size) - 32'd1;
    next_addr = inc;
    if (burst == BURST_FIXED) begin
      next_addr = a;
    end else if (burst == BURST_WRAP &&
                 (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
      next_addr = (a & ~mask) | (inc & mask);
    end
  endfunction

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      rd_pri_q <= 1'b1;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_pri_q <= rd_pri_d;
      id_q     <= id_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rd_pri_d   = rd_pri_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    beat_d     = beat_q;
    err_d      = err_q;
    last_beat  = (beat_q == len_q);

    arready    = 1'b0;
    awready    = 1'b0;
    wready     = 1'b0;
    rvalid     = 1'b0;
    rlast      = 1'b0;
    bvalid     = 1'b0;
    rid        = id_q;
    rdata      = sram_rdata;
    rresp      = RESP_OKAY;
    bid        = id_q;
    bresp      = err_q ? RESP_SLVERR : RESP_OKAY;
    sram_en    = 1'b0;
    sram_wen   = 4'h0;
    sram_addr  = addr_q[ADDR_W+1:2];
    sram_wdata = 32'h0;

    unique case (state_q)
      IDLE: begin
        arready = arvalid & (~awvalid | rd_pri_q);
        awready = awvalid & (~arvalid | ~rd_pri_q);
        if (arvalid && awvalid) begin
          rd_pri_d = ~rd_pri_q;
        end
        if (arready) begin
          id_d    = arid;
          addr_d  = araddr;
          len_d   = arlen;
          size_d  = (arsize > 3'd2) ? 2'd2 : arsize[1:0];
          burst_d = arburst;
          beat_d  = 4'd0;
          state_d = RD_REQ;
        end else if (awready) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = (awsize > 3'd2) ? 2'd2 : awsize[1:0];
          burst_d = awburst;
          beat_d  = 4'd0;
          err_d   = 1'b0;
          state_d = WR_DATA;
        end
      end

      RD_REQ: begin
        sram_en = 1'b1;
        state_d = RD_RESP;
      end

      // SRAM output is held while sram_en is low, so rdata stays stable under back-pressure.
      RD_RESP: begin
        rvalid = 1'b1;
        rlast  = last_beat;
        if (rready) begin
          if (last_beat) begin
            state_d = IDLE;
          end else begin
            addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
            beat_d  = beat_q + 4'd1;
            state_d = RD_REQ;
          end
        end
      end

      // Beat count alone ends the burst; a misplaced wlast only flags an error.
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          sram_en    = 1'b1;
          sram_wen   = wstrb;
          sram_wdata = wdata;
          addr_d     = next_addr(addr_q, len_q, size_q, burst_q);
          beat_d     = beat_q + 4'd1;
          if (wlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = WR_RESP;
          end
        end
      end

      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Bench for axi_sram_slave: directed scenarios plus random bursts checked against an
// array-based memory model with arithmetic beat-address computation.
module tb_axi_sram_slave;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [ID_W-1:0]   arid, rid, awid, wid, bid;
  logic [31:0]       araddr, awaddr, rdata, wdata;
  logic [3:0]        arlen, awlen, wstrb;
  logic [2:0]        arsize, awsize;
  logic [1:0]        arburst, awburst, rresp, bresp;
  logic              arvalid, arready, rlast, rvalid, rready;
  logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [31:0]       sram_wdata, sram_rdata;

  logic [31:0] sram    [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic        wl [16];

  int n_checks = 0;
  int n_pass   = 0;

  axi_sram_slave #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  always #5 aclk = ~aclk;

  // Synchronous single-port SRAM; read data is held while not enabled.
  always @(posedge aclk) begin
    if (sram_en) begin
      if (sram_wen == 4'h0) begin
        sram_rdata <= sram[sram_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (sram_wen[b]) sram[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Byte address of beat i, computed directly from the burst rules.
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input int len, input int size,
                                            input int burst, input int i);
    longint unsigned step, w, base, off;
    int sz;
    sz   = (size > 2) ? 2 : size;
    step = 64'(1) << sz;
    if (burst == 0) return a;
    if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
      w    = 64'(len + 1) * step;
      base = 64'(a) - (64'(a) % w);
      off  = (64'(a) - base + 64'(i) * step) % w;
      return 32'(base + off);
    end
    return 32'(64'(a) + 64'(i) * step);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 32'd4) % 32'(DEPTH));
  endfunction

  task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
    int n;
    @(negedge aclk);
    arid = id; araddr = addr; arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    #1 n = 0;
    while (!arready && n < 200) begin @(negedge aclk); #1 n++; end
    check("ar_ready", 32'(arready), 32'd1);
    @(posedge aclk);
    #1 arvalid = 1'b0;
  endtask

  task automatic recv_r(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                        input int size, input int burst, input int stall);
    for (int i = 0; i <= len; i++) begin
      int n;
      logic [31:0] exp;
      n = 0;
      do begin @(negedge aclk); n++; end while (!rvalid && n < 200);
      check("r_latency", 32'(n), 32'd2);
      exp = ref_mem[word_of(beat_addr(addr, len, size, burst, i))];
      for (int s = 0; s < stall; s++) begin
        check("r_hold_valid", 32'(rvalid), 32'd1);
        check("r_hold_data", rdata, exp);
        check("r_hold_last", 32'(rlast), 32'(i == len));
        @(negedge aclk);
      end
      check("r_valid", 32'(rvalid), 32'd1);
      check("r_data", rdata, exp);
      check("r_last", 32'(rlast), 32'(i == len));
      check("r_id", 32'(rid), 32'(id));
      check("r_resp", 32'(rresp), 32'd0);
      rready = 1'b1;
      @(posedge aclk);
      #1 rready = 1'b0;
    end
  endtask

  task automatic send_aw(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
    int n;
    @(negedge aclk);
    awid = id; awaddr = addr; awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    #1 n = 0;
    while (!awready && n < 200) begin @(negedge aclk); #1 n++; end
    check("aw_ready", 32'(awready), 32'd1);
    @(posedge aclk);
    #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input int len);
    for (int i = 0; i <= len; i++) begin
      int n;
      repeat ($urandom_range(0, 1)) @(negedge aclk);
      @(negedge aclk);
      wid = 4'(i); wdata = wd[i]; wstrb = ws[i]; wlast = wl[i]; wvalid = 1'b1;
      #1 n = 0;
      while (!wready && n < 200) begin @(negedge aclk); #1 n++; end
      check("w_ready", 32'(wready), 32'd1);
      @(posedge aclk);
      #1 wvalid = 1'b0; wlast = 1'b0;
    end
  endtask

  task automatic recv_b(input logic [ID_W-1:0] id, input logic [1:0] exp_resp, input int stall);
    int n;
    n = 0;
    do begin @(negedge aclk); n++; end while (!bvalid && n < 200);
    for (int s = 0; s < stall; s++) begin
      check("b_hold_valid", 32'(bvalid), 32'd1);
      check("b_hold_resp", 32'(bresp), 32'(exp_resp));
      @(negedge aclk);
    end
    check("b_valid", 32'(bvalid), 32'd1);
    check("b_id", 32'(bid), 32'(id));
    check("b_resp", 32'(bresp), 32'(exp_resp));
    bready = 1'b1;
    @(posedge aclk);
    #1 bready = 1'b0;
  endtask

  // Apply a whole write burst to the reference memory and derive its response.
  task automatic model_write(input logic [31:0] addr, input int len, input int size,
                             input int burst, output logic [1:0] resp);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i <= len; i++) begin
      int w;
      w = word_of(beat_addr(addr, len, size, burst, i));
      for (int b = 0; b < 4; b++)
        if (ws[i][b]) ref_mem[w][8*b +: 8] = wd[i][8*b +: 8];
      if (wl[i] != (i == len)) bad = 1'b1;
    end
    resp = bad ? 2'b10 : 2'b00;
  endtask

  task automatic fill_w(input int len);
    for (int i = 0; i <= len; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'($urandom);
      wl[i] = (i == len);
    end
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input int stall);
    send_ar(id, addr, len, size, burst);
    recv_r(id, addr, len, size, burst, stall);
  endtask

  task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input int stall);
    logic [1:0] er;
    model_write(addr, len, size, burst, er);
    send_aw(id, addr, len, size, burst);
    send_w(len);
    recv_b(id, er, stall);
  endtask

  // AR and AW raised together; the winner is served first, the loser waits its turn.
  task automatic pair_test(input logic exp_read_first);
    logic [1:0] er;
    logic [ID_W-1:0] rd_id, wr_id;
    logic [31:0] ra, wa;
    rd_id = 4'($urandom); wr_id = 4'($urandom);
    ra = 32'h0000_0040; wa = 32'h0000_0044;
    fill_w(0);
    @(negedge aclk);
    arid = rd_id; araddr = ra; arlen = 4'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    awid = wr_id; awaddr = wa; awlen = 4'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    #1;
    check("pair_arready", 32'(arready), 32'(exp_read_first));
    check("pair_awready", 32'(awready), 32'(!exp_read_first));
    @(posedge aclk);
    if (exp_read_first) begin
      #1 arvalid = 1'b0;
      recv_r(rd_id, ra, 0, 2, 1, 0);
      check("pair_aw_after_read", 32'(awready), 32'd1);
      model_write(wa, 0, 2, 1, er);
      send_aw(wr_id, wa, 0, 2, 1);
      send_w(0);
      recv_b(wr_id, er, 0);
    end else begin
      #1 awvalid = 1'b0;
      model_write(wa, 0, 2, 1, er);
      send_w(0);
      recv_b(wr_id, er, 0);
      check("pair_ar_after_write", 32'(arready), 32'd1);
      send_ar(rd_id, ra, 0, 2, 1);
      recv_r(rd_id, ra, 0, 2, 1, 0);
    end
  endtask

  initial begin
    logic [31:0] v;
    int n;
    aresetn = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    rready = 1'b0; bready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      v = $urandom; sram[i] = v; ref_mem[i] = v;
    end
    repeat (3) @(negedge aclk);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_sram_en", 32'(sram_en), 32'd0);
    check("rst_sram_wen", 32'(sram_wen), 32'd0);
    check("rst_rid", 32'(rid), 32'd0);
    check("rst_bid", 32'(bid), 32'd0);
    check("rst_resp", 32'({rresp, bresp}), 32'd0);
    aresetn = 1'b1;

    // Single read of a known word
    sram[4] = 32'hDEAD_BEEF; ref_mem[4] = 32'hDEAD_BEEF;
    do_read(4'h3, 32'h10, 0, 2, 1, 0);

    // INCR write of 1..4 then read back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; wl[i] = (i == 3); end
    do_write(4'h5, 32'h100, 3, 2, 1, 1);
    for (int i = 0; i < 4; i++) check("incr_wr_mem", sram[64 + i], 32'(i + 1));

    // Back-pressured INCR read
    do_read(4'h1, 32'h200, 3, 2, 1, 5);

    // WRAP read 0x18: words 6,7,4,5
    for (int i = 4; i < 8; i++) begin v = 32'h1111_0000 + 32'(i); sram[i] = v; ref_mem[i] = v; end
    do_read(4'h2, 32'h18, 3, 2, 2, 0);

    // FIXED write: only word 8 changes, last beat wins
    for (int i = 0; i < 3; i++) begin wd[i] = 32'hA0A0_0000 + 32'(i); ws[i] = 4'hF; wl[i] = (i == 2); end
    do_write(4'h4, 32'h20, 2, 2, 0, 0);
    check("fixed_wr_word8", sram[8], 32'hA0A0_0002);
    check("fixed_wr_word9", sram[9], ref_mem[9]);
    check("fixed_wr_word10", sram[10], ref_mem[10]);

    // Round-robin arbitration
    pair_test(1'b1);
    pair_test(1'b0);
    pair_test(1'b1);

    // Early wlast: all beats still taken, SLVERR
    fill_w(3);
    wl[1] = 1'b1; wl[3] = 1'b0;
    do_write(4'h9, 32'h80, 3, 2, 1, 0);

    // Reset while a read response is pending
    send_ar(4'h7, 32'h300, 3, 2, 1);
    n = 0;
    do begin @(negedge aclk); n++; end while (!rvalid && n < 200);
    check("pre_rst_rvalid", 32'(rvalid), 32'd1);
    #1 aresetn = 1'b0;
    #1;
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_rlast", 32'(rlast), 32'd0);
    check("mid_rst_sram_en", 32'(sram_en), 32'd0);
    check("mid_rst_rid", 32'(rid), 32'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    pair_test(1'b1);

    // Random bursts
    for (int t = 0; t < 60; t++) begin
      logic [ID_W-1:0] id;
      logic [31:0] a;
      int len, size, burst, stall;
      id = 4'($urandom); a = $urandom; len = int'($urandom_range(0, 15));
      size = int'($urandom_range(0, 3)); burst = int'($urandom_range(0, 2));
      stall = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        do_read(id, a, len, size, burst, stall);
      end else begin
        fill_w(len);
        if ($urandom_range(0, 9) == 0) begin
          int k;
          k = int'($urandom_range(0, len));
          wl[k] = ~wl[k];
        end
        do_write(id, a, len, size, burst, stall);
      end
    end

    for (int i = 0; i < int'(DEPTH); i++) check("final_mem", sram[i], ref_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
